// File: rtl/led_colour_driver.sv
// led_colour_driver
//   Drives one RGB LED from the 3-bit colour code of the lights controller.
//   Each channel (bit0 red, bit1 green, bit2 blue) is PWM modulated by a shared
//   brightness value. Colour and brightness are captured every cycle but only
//   take effect at the PWM period boundary, so a running period is never
//   disturbed by input changes.
//
// Parameters
//   PWM_BITS    width of the PWM counter and brightness; period = 2**PWM_BITS clocks
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   colour      colour code from the lights controller
//   brightness  PWM duty in on-cycles per period
//   led_r/g/b   registered LED drives
//   cur_colour  colour code currently displayed
//   changed     one-cycle pulse after a boundary that changed cur_colour
//
// Build option
//   LED_FADE_EN  when defined, each channel ramps its own level by one step per
//                period toward its target instead of jumping to the new duty.

module led_colour_driver #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic [2:0]          cur_colour,
  output logic                changed
);

  localparam logic [PWM_BITS-1:0] CntMax = '1;
  localparam logic [PWM_BITS-1:0] CntOne = PWM_BITS'(1);

  // Free-running PWM counter
  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  // Input capture stage
  logic [2:0]          colour_q, colour_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;

  // Displayed state, only updated at the period boundary
  logic [2:0]          cur_colour_q, cur_colour_d;
  logic                changed_q, changed_d;

  // Registered LED drives, index 0 red, 1 green, 2 blue
  logic [2:0]          led_q, led_d;

  logic                boundary;

`ifdef LED_FADE_EN
  logic [PWM_BITS-1:0] lvl_q [3];
  logic [PWM_BITS-1:0] lvl_d [3];
  logic [PWM_BITS-1:0] target [3];
`else
  logic [PWM_BITS-1:0] duty_q, duty_d;
`endif

  // The edge on which cnt wraps is the only point where displayed state moves.
  assign boundary = (cnt_q == CntMax);

  always_comb begin
    cnt_d        = cnt_q + CntOne;
    colour_d     = colour;
    bright_d     = brightness;
    cur_colour_d = cur_colour_q;
    changed_d    = 1'b0;
    if (boundary) begin
      cur_colour_d = colour_q;
      changed_d    = (colour_q != cur_colour_q);
    end
  end

`ifdef LED_FADE_EN
  // A disabled channel fades toward zero rather than switching off abruptly.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      target[i] = colour_q[i] ? bright_q : '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      lvl_d[i] = lvl_q[i];
      if (boundary) begin
        if (lvl_q[i] < target[i]) begin
          lvl_d[i] = lvl_q[i] + CntOne;
        end else if (lvl_q[i] > target[i]) begin
          lvl_d[i] = lvl_q[i] - CntOne;
        end
      end
    end
  end

  // Level already encodes channel enable, so no colour gating here.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      led_d[i] = (cnt_q < lvl_q[i]);
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      duty_d = bright_q;
    end
  end

  // cnt never exceeds MAX, so duty MAX leaves exactly one low cycle per period.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      led_d[i] = cur_colour_q[i] & (cnt_q < duty_q);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      colour_q     <= '0;
      bright_q     <= '0;
      cur_colour_q <= '0;
      changed_q    <= 1'b0;
      led_q        <= '0;
`ifdef LED_FADE_EN
      for (int unsigned i = 0; i < 3; i++) begin
        lvl_q[i] <= '0;
      end
`else
      duty_q       <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      colour_q     <= colour_d;
      bright_q     <= bright_d;
      cur_colour_q <= cur_colour_d;
      changed_q    <= changed_d;
      led_q        <= led_d;
`ifdef LED_FADE_EN
      for (int unsigned i = 0; i < 3; i++) begin
        lvl_q[i] <= lvl_d[i];
      end
`else
      duty_q       <= duty_d;
`endif
    end
  end

  assign led_r      = led_q[0];
  assign led_g      = led_q[1];
  assign led_b      = led_q[2];
  assign cur_colour = cur_colour_q;
  assign changed    = changed_q;

endmodule
